nand3_resp_checker: RTL and testbench

- Hardware self-checking monitor for the 3-input NAND cell. It is the receiving end of the stimulus interface that drives A/B/C into the gate.
- Samples the applied input vector and the gate output Y every clock and compares Y against the expected NAND value.
- Tracks coverage of all 8 input combinations, counts mismatches and reports pass/fail.
- Sits beside the gate in simulation and FPGA bring-up benches, so that a stimulus source plus this block form a closed loop with no waveform inspection needed.

---
 rtl/nand3_resp_checker.sv | 158 +++++++++++++++
 tb/tb_nand3_resp_checker.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand3_resp_checker.sv
// Response checker for a 3-input NAND cell: compares the gate output against the
// expected NAND of the (optionally delayed) stimulus vector, tracking coverage and errors.
module nand3_resp_checker #(
    parameter int LATENCY    = 0,
    parameter int ERR_W      = 8,
    parameter int MAX_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       cov_mask,
    output logic             first_err_valid,
    output logic [2:0]       first_err_vec
);

    localparam int TW          = $clog2(MAX_CYCLES + 1);
    localparam int SETTLE_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam int SW          = (SETTLE_LAST > 0) ? $clog2(SETTLE_LAST + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] check_cnt;

    logic       accept_start;
    logic       shift_en;
    logic       d_en;
    logic       da;
    logic       db;
    logic       dc;
    logic [2:0] vec;
    logic       expected;
    logic       sample;
    logic       mismatch;
    logic [7:0] vec_bit;
    logic [7:0] cov_next;
    logic       cov_full;
    logic       time_up;
    logic       settle_end;
    logic       err_zero_next;

    assign accept_start = start && ((state == IDLE) || (state == DONE));
    assign shift_en     = (state != IDLE);

    // The stimulus vector is delayed to line up with the gate response; a start
    // flushes it so stale vectors from the previous run are never compared.
    if (LATENCY == 0) begin : g_nodelay
        assign {d_en, da, db, dc} = {en, a, b, c};
    end else begin : g_pipe
        logic [3:0] stage [LATENCY];

        always_ff @(posedge clk) begin
            if (!rst_n || accept_start) begin
                for (int i = 0; i < LATENCY; i++) begin
                    stage[i] <= 4'b0000;
                end
            end else if (shift_en) begin
                stage[0] <= {en, a, b, c};
                for (int i = 1; i < LATENCY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign {d_en, da, db, dc} = stage[LATENCY-1];
    end

    assign vec           = {da, db, dc};
    assign expected      = ~(da & db & dc);
    assign sample        = (state == CHECK) && d_en;
    assign mismatch      = sample && (y != expected);
    assign vec_bit       = 8'b0000_0001 << vec;
    assign cov_next      = sample ? (cov_mask | vec_bit) : cov_mask;
    assign cov_full      = (cov_next == 8'hFF);
    assign time_up       = (check_cnt == TW'(MAX_CYCLES - 1));
    assign settle_end    = (settle_cnt == SW'(SETTLE_LAST));
    assign err_zero_next = (err_cnt == '0) && !mismatch;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (settle_end) state_next = CHECK;
            CHECK:   if (cov_full || time_up) state_next = DONE;
            DONE:    if (start) state_next = SETTLE;
            default: state_next = IDLE;
        endcase
    end

    // Statistics are frozen outside CHECK so a finished run stays readable in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            check_cnt       <= '0;
            err_cnt         <= '0;
            cov_mask        <= 8'h00;
            first_err_valid <= 1'b0;
            first_err_vec   <= 3'b000;
            pass            <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            state <= state_next;
            if (accept_start) begin
                settle_cnt      <= '0;
                check_cnt       <= '0;
                err_cnt         <= '0;
                cov_mask        <= 8'h00;
                first_err_valid <= 1'b0;
                first_err_vec   <= 3'b000;
                pass            <= 1'b0;
                timeout         <= 1'b0;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt + SW'(1);
                check_cnt  <= '0;
            end else if (state == CHECK) begin
                check_cnt <= check_cnt + TW'(1);
                cov_mask  <= cov_next;
                if (mismatch) begin
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                    end
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= vec;
                    end
                end
                // Full coverage wins over the timeout when both land on the same cycle.
                if (cov_full || time_up) begin
                    pass    <= err_zero_next && cov_full;
                    timeout <= !cov_full;
                end
            end
        end
    end

    assign busy = (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);

endmodule

// File: tb/tb_nand3_resp_checker.sv
// Directed bench for nand3_resp_checker: three instances cover zero latency,
// two-cycle latency, and a short timeout with a 2-bit error counter.
module tb_nand3_resp_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic en, a, b, c;
    logic start0, start2, startt;
    logic y0, y2, yt;
    logic fault0, one_stage, stuck;
    logic r1, r2;

    logic       busy0, done0, pass0, tmo0, fev0_valid;
    logic [7:0] err0, cov0;
    logic [2:0] fev0;

    logic       busy2, done2, pass2, tmo2, fev2_valid;
    logic [7:0] err2, cov2;
    logic [2:0] fev2;

    logic       busyt, donet, passt, tmot, fevt_valid;
    logic [1:0] errt;
    logic [7:0] covt;
    logic [2:0] fevt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r1 <= ~(a & b & c);
        r2 <= r1;
    end

    assign y0 = (fault0 && a && b && c) ? 1'b1 : ~(a & b & c);
    assign y2 = one_stage ? r1 : r2;
    assign yt = stuck ? 1'b0 : ~(a & b & c);

    nand3_resp_checker #(.LATENCY(0), .ERR_W(8), .MAX_CYCLES(1000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .en(en), .a(a), .b(b), .c(c), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .timeout(tmo0), .err_cnt(err0),
        .cov_mask(cov0), .first_err_valid(fev0_valid), .first_err_vec(fev0)
    );

    nand3_resp_checker #(.LATENCY(2), .ERR_W(8), .MAX_CYCLES(1000)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .en(en), .a(a), .b(b), .c(c), .y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .timeout(tmo2), .err_cnt(err2),
        .cov_mask(cov2), .first_err_valid(fev2_valid), .first_err_vec(fev2)
    );

    nand3_resp_checker #(.LATENCY(0), .ERR_W(2), .MAX_CYCLES(20)) dutt (
        .clk(clk), .rst_n(rst_n), .start(startt), .en(en), .a(a), .b(b), .c(c), .y(yt),
        .busy(busyt), .done(donet), .pass(passt), .timeout(tmot), .err_cnt(errt),
        .cov_mask(covt), .first_err_valid(fevt_valid), .first_err_vec(fevt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input logic [2:0] v);
        en = 1'b1;
        {a, b, c} = v;
        tick();
    endtask

    task automatic drive_idle();
        en = 1'b0;
        {a, b, c} = 3'b000;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy0, done0, pass0, tmo0, fev0_valid, err0, cov0, fev0} !== 23'd0) begin
            failures++;
            $display("[TB] FAIL reset_dut0: got %h required 0",
                     {busy0, done0, pass0, tmo0, fev0_valid, err0, cov0, fev0});
        end
        checks++;
        if ({busy2, done2, cov2, err2} !== 18'd0) begin
            failures++;
            $display("[TB] FAIL reset_dut2: got %h required 0", {busy2, done2, cov2, err2});
        end
        checks++;
        if ({busyt, donet, covt, errt} !== 12'd0) begin
            failures++;
            $display("[TB] FAIL reset_dutt: got %h required 0", {busyt, donet, covt, errt});
        end
    endtask

    task automatic test_correct_gate();
        fault0 = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL correct_busy: got %b required 1", busy0);
        end
        tick();
        for (int i = 0; i < 8; i++) drive_vec(3'(i));
        drive_idle();
        checks++;
        if ({done0, busy0} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL correct_done_timing: got done,busy=%b required 10", {done0, busy0});
        end
        checks++;
        if ({cov0, err0, pass0, tmo0, fev0_valid} !== {8'hFF, 8'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL correct_stats: got cov=%h err=%0d pass=%b tmo=%b fev=%b required FF 0 1 0 0",
                     cov0, err0, pass0, tmo0, fev0_valid);
        end
    endtask

    task automatic test_faulty_gate();
        fault0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        checks++;
        if ({done0, busy0, pass0, cov0} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("[TB] FAIL restart_clear: got done=%b busy=%b pass=%b cov=%h required 0 1 0 00",
                     done0, busy0, pass0, cov0);
        end
        tick();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 8; i++) drive_vec(3'(i));
        drive_idle();
        checks++;
        if ({done0, err0, fev0_valid, fev0, pass0, cov0} !== {1'b1, 8'd1, 1'b1, 3'b111, 1'b0, 8'hFF}) begin
            failures++;
            $display("[TB] FAIL faulty_stats: got done=%b err=%0d fevv=%b fev=%b pass=%b cov=%h required 1 1 1 111 0 FF",
                     done0, err0, fev0_valid, fev0, pass0, cov0);
        end
    endtask

    task automatic test_start_ignored();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        drive_vec(3'd7);
        start0 = 1'b1;
        drive_vec(3'd0);
        start0 = 1'b0;
        checks++;
        if ({busy0, err0, cov0} !== {1'b1, 8'd1, 8'h81}) begin
            failures++;
            $display("[TB] FAIL start_ignored: got busy=%b err=%0d cov=%h required 1 1 81", busy0, err0, cov0);
        end
        for (int i = 1; i < 7; i++) drive_vec(3'(i));
        drive_idle();
        checks++;
        if ({done0, err0, fev0} !== {1'b1, 8'd1, 3'b111}) begin
            failures++;
            $display("[TB] FAIL start_ignored_end: got done=%b err=%0d fev=%b required 1 1 111", done0, err0, fev0);
        end
    endtask

    task automatic test_latency2(input logic single, input logic [7:0] exp_err,
                                 input logic exp_pass, input logic [2:0] exp_fev);
        int n;
        one_stage = single;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 8; i++) drive_vec(3'(i));
        drive_idle();
        n = 0;
        while (!done2 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 2) begin
            failures++;
            $display("[TB] FAIL lat2_done_timing single=%b: got %0d extra cycles required 2", single, n);
        end
        checks++;
        if ({done2, err2, pass2, cov2} !== {1'b1, exp_err, exp_pass, 8'hFF}) begin
            failures++;
            $display("[TB] FAIL lat2_stats single=%b: got done=%b err=%0d pass=%b cov=%h required 1 %0d %b FF",
                     single, done2, err2, pass2, cov2, exp_err, exp_pass);
        end
        if (exp_err != 8'd0) begin
            checks++;
            if ({fev2_valid, fev2} !== {1'b1, exp_fev}) begin
                failures++;
                $display("[TB] FAIL lat2_first_err: got %b,%b required 1,%b", fev2_valid, fev2, exp_fev);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        stuck = 1'b0;
        startt = 1'b1;
        tick();
        startt = 1'b0;
        tick();
        n = 1;
        for (int i = 0; i < 7; i++) begin
            drive_vec(3'(i));
            n++;
        end
        drive_idle();
        while (!donet && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 21) begin
            failures++;
            $display("[TB] FAIL timeout_cycles: got %0d required 21", n);
        end
        checks++;
        if ({donet, tmot, passt, covt, errt} !== {1'b1, 1'b1, 1'b0, 8'h7F, 2'd0}) begin
            failures++;
            $display("[TB] FAIL timeout_stats: got done=%b tmo=%b pass=%b cov=%h err=%0d required 1 1 0 7F 0",
                     donet, tmot, passt, covt, errt);
        end
    endtask

    task automatic test_saturation();
        stuck = 1'b1;
        startt = 1'b1;
        tick();
        startt = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) drive_vec(3'(i));
        drive_idle();
        checks++;
        if ({donet, errt, fevt_valid, fevt, passt, tmot} !== {1'b1, 2'd3, 1'b1, 3'b000, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL saturation: got done=%b err=%0d fevv=%b fev=%b pass=%b tmo=%b required 1 3 1 000 0 0",
                     donet, errt, fevt_valid, fevt, passt, tmot);
        end
    endtask

    task automatic test_reset_mid_run();
        fault0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        drive_vec(3'd7);
        drive_vec(3'd0);
        checks++;
        if ({busy0, err0} !== {1'b1, 8'd1}) begin
            failures++;
            $display("[TB] FAIL midrun_pre: got busy=%b err=%0d required 1 1", busy0, err0);
        end
        drive_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy0, done0, pass0, tmo0, fev0_valid, err0, cov0, fev0} !== 23'd0) begin
            failures++;
            $display("[TB] FAIL midrun_reset: got %h required 0",
                     {busy0, done0, pass0, tmo0, fev0_valid, err0, cov0, fev0});
        end
        drive_vec(3'd7);
        drive_vec(3'd3);
        drive_idle();
        checks++;
        if ({busy0, cov0, err0} !== 17'd0) begin
            failures++;
            $display("[TB] FAIL idle_ignores: got busy=%b cov=%h err=%0d required 0 00 0", busy0, cov0, err0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        startt = 1'b0;
        fault0 = 1'b0;
        one_stage = 1'b0;
        stuck = 1'b0;
        drive_idle();
        tick();
        tick();
        rst_n = 1'b1;
        test_reset();
        test_correct_gate();
        test_faulty_gate();
        test_start_ignored();
        test_latency2(1'b0, 8'd0, 1'b1, 3'b000);
        test_latency2(1'b1, 8'd2, 1'b0, 3'b110);
        test_timeout();
        test_saturation();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
